stack_alu_sequencer: RTL and testbench
======================================

Name: stack_alu_sequencer

Overview:
Instruction issuer and result collector for the stack-based ALU; it drives the ALU's opcode and operand inputs. A small internal program memory is loaded over a write port. On start, the sequencer issues one instruction per clock, captures every popped result with its overflow flag, and raises done when the pipeline has drained. The block turns the hand-written stimulus sequences used for ALU bring-up into a reusable, synthesizable on-chip driver.

Parameters:
N, 16, ALU data width; matches the ALU's n parameter.
DEPTH, 32, program memory entries; must be a power of two.
AW, 5, program address width, log2(DEPTH).

Ports:
clk  input  1  rising-edge clock, shared with the ALU
rst_n  input  1  asynchronous active-low reset
prog_we  input  1  program write strobe; ignored while busy
prog_addr  input  AW  program write address
prog_opcode  input  3  opcode to store
prog_operand  input  N  operand to store
prog_len  input  AW+1  number of instructions to run; sampled on start
start  input  1  run request; ignored while busy
alu_opcode  output  3  to ALU opcode input
alu_in  output  N  to ALU data input
alu_out  input  N  from ALU output
alu_overflow  input  1  from ALU overflow output
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle completion pulse
pc  output  AW  index of the instruction currently driven
res_valid  output  1  one-cycle pulse; res_data and res_ovf are valid
res_data  output  N  captured ALU result
res_ovf  output  1  overflow captured with res_data
ovf_sticky  output  1  OR of overflow from every add/mul in the run

Behaviour:
- Opcode encoding (3-bit):
  - 100 add, 101 multiply, 110 push(alu_in), 111 pop.
  - 0xx is no-op.
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - alu_opcode=000, alu_in=0, busy=0, done=0, pc=0, res_valid=0, res_data=0, res_ovf=0, ovf_sticky=0.
  - Program memory is not cleared. Reset mid-run aborts the run with no done pulse.
- FSM states: IDLE, ISSUE, DRAIN1, DRAIN2.
  - IDLE:
    - alu_opcode=000.
    - prog_we writes memory at the edge.
    - start with effective length L≥1: latch L, clear ovf_sticky, pc=0, go to ISSUE.
    - start with L=0: done pulses the next cycle, busy stays 0, nothing is issued.
  - ISSUE:
    - Each cycle, alu_opcode/alu_in = mem[pc].
    - pc increments each edge.
    - After instruction L-1 has been driven for one cycle, go to DRAIN1.
  - DRAIN1, DRAIN2:
    - alu_opcode=000.
    - At the DRAIN2 exit edge, go to IDLE and assert done for one cycle; busy falls in that same cycle.
- Effective length: L = min(prog_len, DEPTH).
- Timing:
  - Instruction i is driven during cycle i+1 after start is accepted.
  - The ALU samples it at the end of that cycle.
  - alu_out/alu_overflow are valid in the following cycle, and the sequencer registers them at that cycle's end.
- Capture pipeline:
  - A 2-stage tag pipe tracks issued opcodes.
  - A pop issued in cycle k gives res_valid=1 in cycle k+2, with res_data=alu_out and res_ovf=alu_overflow as sampled at the end of cycle k+1.
  - For add/mul, alu_overflow sampled at the same point is ORed into ovf_sticky.
  - Push and no-op produce no capture.
- Consecutive pops give back-to-back res_valid pulses. There is no backpressure, so the consumer must accept one result per cycle.
- res_data holds its last value between pulses. ovf_sticky holds until the next accepted start.
- The last instruction's capture occurs by DRAIN2, so every result is delivered no later than the done cycle.
- start and prog_we are both ignored while busy=1. A start coinciding with the done cycle is accepted, because the FSM is IDLE then.
- Total run: busy high for L+2 cycles; done in cycle L+3 after start is accepted.

Test Plan:
- Program push 5, push 3, add, pop; start with prog_len=4 → exactly one res_valid, res_data=8, res_ovf=0; done 7 cycles after start; ovf_sticky=0.
- Program push 300, push 500, mul, pop (N=16) → res_data=18928 (150000 mod 65536), ovf_sticky=1 at done.
- Program push 1,2,3,4,5 then pop×5 → five consecutive res_valid pulses with res_data 5,4,3,2,1; busy high 12 cycles.
- prog_len=0 → done one cycle after start; busy stays 0; alu_opcode stays 000.
- start pulsed again mid-run and prog_we asserted mid-run → run unaffected, memory unchanged; a start on the done cycle launches a second run.
- rst_n low at pc=2 → all outputs zero immediately; no done. A rerun after release reproduces the first test's results, proving memory was retained.

Source files
------------

// File: rtl/stack_alu_sequencer.sv
// stack_alu_sequencer: on-chip program memory plus issue/capture sequencer for the
// stack ALU. A loaded program of up to DEPTH instructions is issued one per clock.
// Popped results come back with their overflow flag. done pulses once the pipe has drained.
module stack_alu_sequencer #(
   parameter int N     = 16,
   parameter int DEPTH = 32,
   parameter int AW    = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          prog_we,
   input  logic [AW-1:0] prog_addr,
   input  logic [2:0]    prog_opcode,
   input  logic [N-1:0]  prog_operand,
   input  logic [AW:0]   prog_len,
   input  logic          start,
   output logic [2:0]    alu_opcode,
   output logic [N-1:0]  alu_in,
   input  logic [N-1:0]  alu_out,
   input  logic          alu_overflow,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] pc,
   output logic          res_valid,
   output logic [N-1:0]  res_data,
   output logic          res_ovf,
   output logic          ovf_sticky
);

   // Opcodes the sequencer itself must recognise (push and 0xx no-op need no special handling).
   localparam logic [2:0]  OP_NOP    = 3'b000;
   localparam logic [2:0]  OP_ADD    = 3'b100;
   localparam logic [2:0]  OP_MUL    = 3'b101;
   localparam logic [2:0]  OP_POP    = 3'b111;
   localparam logic [AW:0] DEPTH_LEN = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN1,
      S_DRAIN2
   } state_t;

   state_t        r_state;
   state_t        w_next_state;

   logic [2:0]    r_mem_op [DEPTH];
   logic [N-1:0]  r_mem_in [DEPTH];

   logic [AW-1:0] r_pc;
   logic [AW:0]   r_len;
   logic          r_done;
   logic [2:0]    r_tag;
   logic          r_res_valid;
   logic [N-1:0]  r_res_data;
   logic          r_res_ovf;
   logic          r_ovf_sticky;

   logic [AW:0]   w_len_eff;
   logic          w_idle;
   logic          w_start_run;
   logic          w_start_empty;
   logic          w_last;
   logic [2:0]    w_alu_opcode;
   logic [N-1:0]  w_alu_in;

   // Program length is clamped to the memory size; a zero length only produces done.
   assign w_len_eff     = (prog_len > DEPTH_LEN) ? DEPTH_LEN : prog_len;
   assign w_idle        = (r_state == S_IDLE);
   assign w_start_run   = w_idle && start && (w_len_eff != '0);
   assign w_start_empty = w_idle && start && (w_len_eff == '0);
   assign w_last        = ({1'b0, r_pc} == (r_len - (AW+1)'(1)));

   // State register.
   // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next_state;
   end

   // Next-state and ALU drive: memory contents are driven only while issuing.
   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      w_next_state = r_state;
      w_alu_opcode = OP_NOP;
      w_alu_in     = '0;
      case (r_state)
         S_IDLE: begin
            if (w_start_run) w_next_state = S_ISSUE;
         end
         S_ISSUE: begin
            w_alu_opcode = r_mem_op[r_pc];
            w_alu_in     = r_mem_in[r_pc];
            if (w_last) w_next_state = S_DRAIN1;
         end
         S_DRAIN1: w_next_state = S_DRAIN2;
         S_DRAIN2: w_next_state = S_IDLE;
         default:  w_next_state = S_IDLE;
      endcase
   end

   // Program memory writes, accepted only while idle.
   // NOTE: the memory has no reset on purpose; a program survives rst_n and only the write port changes it.
   always_ff @(posedge clk) begin
      if (prog_we && w_idle) begin
         r_mem_op[prog_addr] <= prog_opcode;
         r_mem_in[prog_addr] <= prog_operand;
      end
   end

   // Run control: length latch, program counter and the one-cycle done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc   <= '0;
         r_len  <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= (r_state == S_DRAIN2) || w_start_empty;
         if (w_start_run) begin
            r_pc  <= '0;
            r_len <= w_len_eff;
         end else if (r_state == S_ISSUE) begin
            r_pc  <= r_pc + AW'(1);
         end
      end
   end

   // Capture pipe: stage 1 remembers the opcode the ALU just sampled; stage 2 registers its result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tag        <= OP_NOP;
         r_res_valid  <= 1'b0;
         r_res_data   <= '0;
         r_res_ovf    <= 1'b0;
         r_ovf_sticky <= 1'b0;
      end else begin
         r_tag       <= w_alu_opcode;
         r_res_valid <= (r_tag == OP_POP);
         if (r_tag == OP_POP) begin
            r_res_data <= alu_out;
            r_res_ovf  <= alu_overflow;
         end
         if (w_start_run)
            r_ovf_sticky <= 1'b0;
         else if ((r_tag == OP_ADD) || (r_tag == OP_MUL))
            r_ovf_sticky <= r_ovf_sticky | alu_overflow;
      end
   end

   assign alu_opcode = w_alu_opcode;
   assign alu_in     = w_alu_in;
   assign busy       = !w_idle;
   assign done       = r_done;
   assign pc         = r_pc;
   assign res_valid  = r_res_valid;
   assign res_data   = r_res_data;
   assign res_ovf    = r_res_ovf;
   assign ovf_sticky = r_ovf_sticky;

endmodule

// File: tb/tb_stack_alu_sequencer.sv
// tb_stack_alu_sequencer: drives the sequencer against a small stack-ALU partner and
// checks every cycle of each run against a program-level model of the expected outputs.
module tb_stack_alu_sequencer;

   localparam int N     = 16;
   localparam int DEPTH = 32;
   localparam int AW    = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          prog_we, start;
   logic [AW-1:0] prog_addr;
   logic [2:0]    prog_opcode;
   logic [N-1:0]  prog_operand;
   logic [AW:0]   prog_len;
   logic [2:0]    alu_opcode;
   logic [N-1:0]  alu_in, alu_out, res_data;
   logic          alu_overflow, busy, done, res_valid, res_ovf, ovf_sticky;
   logic [AW-1:0] pc;

   stack_alu_sequencer #(.N(N), .DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_opcode(prog_opcode),
      .prog_operand(prog_operand), .prog_len(prog_len), .start(start),
      .alu_opcode(alu_opcode), .alu_in(alu_in), .alu_out(alu_out),
      .alu_overflow(alu_overflow), .busy(busy), .done(done), .pc(pc),
      .res_valid(res_valid), .res_data(res_data), .res_ovf(res_ovf),
      .ovf_sticky(ovf_sticky)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- stack ALU partner: samples opcode at the edge, answers next cycle
   logic          alu_clr = 1'b0;
   logic [N-1:0]  a_val [64];
   bit            a_ovf [64];
   int            a_sp = 0;

   always @(posedge clk) begin
      logic [N-1:0] x, y;
      bit           xo;
      logic [N:0]   s;
      logic [2*N-1:0] p;
      if (!rst_n || alu_clr) begin
         a_sp = 0;
         if (!rst_n) begin
            alu_out      <= '0;
            alu_overflow <= 1'b0;
         end
      end else if (alu_opcode[2]) begin
         x = '0; y = '0; xo = 1'b0;
         if (alu_opcode != 3'b110 && a_sp > 0) begin a_sp--; x = a_val[a_sp]; xo = a_ovf[a_sp]; end
         if (alu_opcode[1] == 1'b0 && a_sp > 0) begin a_sp--; y = a_val[a_sp]; end
         case (alu_opcode)
            3'b110: begin x = alu_in; xo = 1'b0; end
            3'b100: begin s = {1'b0, x} + {1'b0, y}; x = s[N-1:0]; xo = s[N]; end
            3'b101: begin p = {{N{1'b0}}, x} * {{N{1'b0}}, y}; x = p[N-1:0]; xo = |p[2*N-1:N]; end
            default: ;
         endcase
         if (alu_opcode != 3'b111 && a_sp < 64) begin a_val[a_sp] = x; a_ovf[a_sp] = xo; a_sp++; end
         alu_out      <= x;
         alu_overflow <= xo;
      end
   end

   // ---------------- program-level reference model
   typedef struct { logic [N-1:0] val; bit ovf; } entry_t;

   logic [2:0]    m_op [DEPTH];
   logic [N-1:0]  m_in [DEPTH];
   logic [N-1:0]  m_last_rd = '0;
   bit            m_sticky = 1'b0;

   bit            e_busy [64], e_done [64], e_rv [64], e_ro [64], e_pcchk [64], e_st [64];
   logic [2:0]    e_op [64];
   logic [N-1:0]  e_in [64], e_pv [64], e_rd [64];
   logic [AW-1:0] e_pc [64];
   int            e_last;
   logic [N-1:0]  e_results [$];

   // Expected outputs for cycles 0.. of a run whose start is driven in cycle 0.
   task automatic build_expect(input int len_raw, input bit prev_done);
      entry_t stk [$];
      entry_t a, b, r;
      int L, st_from;
      logic [N:0] sum;
      logic [2*N-1:0] prod;
      logic [N-1:0] rd;
      L       = (len_raw > DEPTH) ? DEPTH : len_raw;
      e_last  = (L == 0) ? 1 : L + 3;
      st_from = 1000;
      e_results.delete();
      for (int c = 0; c < 64; c++) begin
         e_op[c] = 3'b000; e_in[c] = '0; e_pcchk[c] = 1'b0; e_pc[c] = '0;
         e_rv[c] = 1'b0; e_ro[c] = 1'b0; e_pv[c] = '0;
         e_busy[c] = (L != 0) && (c >= 1) && (c <= L + 2);
         e_done[c] = (c == e_last) || (c == 0 && prev_done);
      end
      for (int i = 0; i < L; i++) begin
         e_op[i+1] = m_op[i]; e_in[i+1] = m_in[i]; e_pcchk[i+1] = 1'b1; e_pc[i+1] = AW'(i);
         a = '{'0, 1'b0}; b = '{'0, 1'b0};
         case (m_op[i])
            3'b110: stk.push_back('{m_in[i], 1'b0});
            3'b100, 3'b101: begin
               if (stk.size() > 0) a = stk.pop_back();
               if (stk.size() > 0) b = stk.pop_back();
               if (m_op[i] == 3'b100) begin
                  sum = {1'b0, a.val} + {1'b0, b.val};
                  r = '{sum[N-1:0], sum[N]};
               end else begin
                  prod = {{N{1'b0}}, a.val} * {{N{1'b0}}, b.val};
                  r = '{prod[N-1:0], prod >= (2*N)'(1 << N)};
               end
               if (r.ovf && i + 3 < st_from) st_from = i + 3;
               stk.push_back(r);
            end
            3'b111: begin
               if (stk.size() > 0) a = stk.pop_back();
               e_rv[i+3] = 1'b1; e_pv[i+3] = a.val; e_ro[i+3] = a.ovf;
               e_results.push_back(a.val);
            end
            default: ;
         endcase
      end
      rd = m_last_rd;
      for (int c = 0; c < 64; c++) begin
         if (e_rv[c]) rd = e_pv[c];
         e_rd[c] = rd;
         e_st[c] = (c == 0 || L == 0) ? m_sticky : (c >= st_from);
      end
      m_last_rd = rd;
      if (L != 0) m_sticky = (st_from < 1000);
   endtask

   // ---------------- compare process
   int           cyc = 0;
   bit           chk_en = 1'b0;
   logic [N-1:0] obs_res [$];
   int           obs_done_cyc = -1;
   int           obs_busy = 0;

   always @(negedge clk) begin
      if (chk_en) begin
         check("busy",       32'(busy),       32'(e_busy[cyc]));
         check("done",       32'(done),       32'(e_done[cyc]));
         check("alu_opcode", 32'(alu_opcode), 32'(e_op[cyc]));
         if (e_pcchk[cyc]) begin
            check("alu_in", 32'(alu_in), 32'(e_in[cyc]));
            check("pc",     32'(pc),     32'(e_pc[cyc]));
         end
         check("res_valid",  32'(res_valid),  32'(e_rv[cyc]));
         check("res_data",   32'(res_data),   32'(e_rd[cyc]));
         if (e_rv[cyc]) check("res_ovf", 32'(res_ovf), 32'(e_ro[cyc]));
         check("ovf_sticky", 32'(ovf_sticky), 32'(e_st[cyc]));
         if (cyc == 0) begin
            obs_res.delete(); obs_done_cyc = -1; obs_busy = 0;
         end else begin
            if (done)      obs_done_cyc = cyc;
            if (busy)      obs_busy++;
            if (res_valid) obs_res.push_back(res_data);
         end
      end
   end

   // ---------------- drivers (entered and left at posedge+1)
   task automatic write_prog(input int addr, input logic [2:0] op, input logic [N-1:0] val);
      prog_we = 1'b1; prog_addr = AW'(addr); prog_opcode = op; prog_operand = val;
      m_op[addr] = op; m_in[addr] = val;
      @(posedge clk); #1;
      prog_we = 1'b0;
   endtask

   // chain=1 returns in the done cycle so the next run can start there.
   task automatic run(input int len_raw, input bit prev_done, input bit chain, input bit disturb);
      build_expect(len_raw, prev_done);
      start = 1'b1; prog_len = (AW+1)'(len_raw); alu_clr = 1'b1; cyc = 0; chk_en = 1'b1;
      for (int c = 1; c <= e_last + 2; c++) begin
         @(posedge clk); #1;
         start = 1'b0; alu_clr = 1'b0; prog_we = 1'b0;
         if (chain && c == e_last) return;
         cyc = c;
         if (disturb && c == 2) begin
            start = 1'b1; prog_len = 7; prog_we = 1'b1;
            prog_addr = 1; prog_opcode = 3'b111; prog_operand = 16'hBEEF;
         end
      end
      @(posedge clk); #1;
      chk_en = 1'b0;
   endtask

   function automatic logic [2:0] rand_op();
      int r = $urandom % 100;
      if (r < 40) return 3'b110;
      if (r < 65) return 3'b111;
      if (r < 77) return 3'b100;
      if (r < 89) return 3'b101;
      return {1'b0, 2'($urandom)};
   endfunction

   function automatic logic [N-1:0] rand_val();
      return ($urandom % 2 == 1) ? N'($urandom % 16) : N'($urandom);
   endfunction

   task automatic load_test1();
      write_prog(0, 3'b110, 5);
      write_prog(1, 3'b110, 3);
      write_prog(2, 3'b100, 0);
      write_prog(3, 3'b111, 0);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bit chained_prev;
      bit ch;
      int len;
      start = 0; prog_we = 0; prog_addr = '0; prog_opcode = '0; prog_operand = '0; prog_len = '0;

      // reset state
      #2;
      check("rst_alu_opcode", 32'(alu_opcode), 0);
      check("rst_alu_in",     32'(alu_in),     0);
      check("rst_busy",       32'(busy),       0);
      check("rst_done",       32'(done),       0);
      check("rst_pc",         32'(pc),         0);
      check("rst_res_valid",  32'(res_valid),  0);
      check("rst_res_data",   32'(res_data),   0);
      check("rst_res_ovf",    32'(res_ovf),    0);
      check("rst_ovf_sticky", 32'(ovf_sticky), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < DEPTH; i++) write_prog(i, rand_op(), rand_val());

      // push 5, push 3, add, pop
      load_test1();
      run(4, 0, 0, 0);
      check("t1_model_count",  32'(e_results.size()), 1);
      check("t1_model_value",  32'(e_results[0]), 8);
      check("t1_result_count", 32'(obs_res.size()), 1);
      check("t1_result",       32'(obs_res[0]), 8);
      check("t1_done_cycle",   32'(obs_done_cyc), 7);
      check("t1_sticky",       32'(ovf_sticky), 0);

      // push 300, push 500, mul, pop
      write_prog(0, 3'b110, 300);
      write_prog(1, 3'b110, 500);
      write_prog(2, 3'b101, 0);
      write_prog(3, 3'b111, 0);
      run(4, 0, 0, 0);
      check("t2_model_value",  32'(e_results[0]), 18928);
      check("t2_result_count", 32'(obs_res.size()), 1);
      check("t2_result",       32'(obs_res[0]), 18928);
      check("t2_sticky",       32'(ovf_sticky), 1);

      // push 1..5, pop x5
      for (int i = 0; i < 5; i++) write_prog(i, 3'b110, N'(i + 1));
      for (int i = 5; i < 10; i++) write_prog(i, 3'b111, 0);
      run(10, 0, 0, 0);
      check("t3_result_count", 32'(obs_res.size()), 5);
      for (int k = 0; k < 5; k++) check("t3_result", 32'(obs_res[k]), 32'(5 - k));
      check("t3_busy_cycles",  32'(obs_busy), 12);
      check("t3_done_cycle",   32'(obs_done_cyc), 13);

      // zero length
      run(0, 0, 0, 0);
      check("t4_done_cycle",  32'(obs_done_cyc), 1);
      check("t4_busy_cycles", 32'(obs_busy), 0);

      // mid-run start/write are ignored; start on the done cycle chains a second run
      load_test1();
      run(4, 0, 1, 1);
      run(4, 1, 0, 0);
      check("t5_result_count", 32'(obs_res.size()), 1);
      check("t5_result",       32'(obs_res[0]), 8);
      check("t5_done_cycle",   32'(obs_done_cyc), 7);

      // reset at pc=2 aborts the run; program survives
      start = 1'b1; prog_len = 4; alu_clr = 1'b1;
      @(posedge clk); #1; start = 1'b0; alu_clr = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("abort_pc_before",   32'(pc),   2);
      check("abort_busy_before", 32'(busy), 1);
      rst_n = 1'b0;
      #1;
      check("abort_alu_opcode", 32'(alu_opcode), 0);
      check("abort_alu_in",     32'(alu_in),     0);
      check("abort_busy",       32'(busy),       0);
      check("abort_done",       32'(done),       0);
      check("abort_pc",         32'(pc),         0);
      check("abort_res_valid",  32'(res_valid),  0);
      check("abort_res_data",   32'(res_data),   0);
      check("abort_res_ovf",    32'(res_ovf),    0);
      check("abort_ovf_sticky", 32'(ovf_sticky), 0);
      m_last_rd = '0; m_sticky = 1'b0;
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("abort_no_done", 32'(done), 0);
      end
      @(posedge clk); #1;
      run(4, 0, 0, 0);
      check("t6_result_count", 32'(obs_res.size()), 1);
      check("t6_result",       32'(obs_res[0]), 8);

      // randomized programs and lengths, some runs chained on the done cycle
      chained_prev = 1'b0;
      for (int r = 0; r < 14; r++) begin
         if (!chained_prev) begin
            int k = $urandom_range(0, 8);
            for (int j = 0; j < k; j++) write_prog($urandom_range(0, DEPTH - 1), rand_op(), rand_val());
         end
         len = ($urandom % 4 == 0) ? $urandom_range(33, 63) : $urandom_range(0, 32);
         ch  = (r < 13) && ($urandom % 3 == 0);
         run(len, chained_prev, ch, 1'b0);
         chained_prev = ch;
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
